// File: rtl/chdr_12sc_to_16sc.sv
// chdr_12sc_to_16sc
//   Receive-side unpacker for CHDR data packets carrying packed 12-bit
//   complex samples ({I12,Q12}, 24 bits, MSB-first across 64-bit lines).
//   Each sample is expanded to {I12,4'h0,Q12,4'h0} and two samples go out per
//   line, earlier sample in the upper half. The header length field is
//   rewritten to H + 4*floor((len-H)/3). Non-data packets (type != 0) and all
//   traffic while disabled pass through verbatim.
//
// Ports
//   clk, reset               clock; asynchronous active-low reset
//   set_stb/set_addr/set_data settings bus; set_data[0] = enable conversion
//   i_tdata/i_tlast/i_tvalid/i_tready   CHDR input stream
//   o_tdata/o_tlast/o_tvalid/o_tready   CHDR output stream (registered)
module chdr_12sc_to_16sc #(
  parameter int BASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

  typedef enum logic [2:0] {HDR, HDR_OUT, TIME, BODY, FLUSH, PASS} state_t;

  state_t        state, state_nx;
  logic          enable;

  // latched header fields of a packet being converted
  logic [15:0]   hdr_hi;      // type/has_time/eob/seqnum
  logic [31:0]   sid_q;
  logic          hdr_last_q;  // header itself carried i_tlast
  logic [14:0]   n_q;         // whole samples announced by the header
  logic [15:0]   olen_q;

  // residue buffer, valid bits MSB-aligned
  logic [127:0]  sbuf, sbuf_nx;
  logic [7:0]    cnt, cnt_nx;
  logic [19:0]   need, need_nx;  // payload bits still to pull from input
  logic          out_done, done_nx;

  logic          unused_bits;
  assign unused_bits = ^set_data[31:1];

  // header arithmetic on the incoming line
  logic [15:0]   h_len, p_len;
  logic [31:0]   prod;
  logic [14:0]   n_c;
  logic [19:0]   need0;
  assign h_len = i_tdata[61] ? 16'd16 : 16'd8;
  assign p_len = i_tdata[47:32] - h_len;
  assign prod  = 32'(p_len) * 32'h0000_AAAB;   // floor(P/3) for any 16-bit P
  assign n_c   = 15'(prod >> 17);
  assign need0 = 20'(n_c) * 20'd24;

  function automatic logic [7:0] floor24(input logic [7:0] c);
    if      (c >= 8'd120) return 8'd120;
    else if (c >= 8'd96)  return 8'd96;
    else if (c >= 8'd72)  return 8'd72;
    else if (c >= 8'd48)  return 8'd48;
    else if (c >= 8'd24)  return 8'd24;
    else                  return 8'd0;
  endfunction

  logic          load_ok, rdy, acc;
  logic          can_pop, pop, pop_last, mark, push;
  logic [7:0]    pop_bits, push_bits, cnt_pop;
  logic [63:0]   pop_line;
  logic [127:0]  sh, push_v, mask;
  logic          ld, ld_last, hdr_ld;
  logic [63:0]   ld_data;

  // output register may take a new line when empty or being drained
  assign load_ok = !o_tvalid || o_tready;

  assign pop_bits = (cnt >= 8'd48) ? 8'd48 : 8'd24;
  // a lone final sample is popped only once no more payload is expected
  assign can_pop  = !out_done && ((cnt >= 8'd48) || (need == 20'd0 && cnt == 8'd24));
  assign pop      = (state == BODY || state == FLUSH) && load_ok && can_pop;
  assign pop_last = (need == 20'd0) && (cnt == pop_bits);
  // early i_tlast left no whole sample: close the packet with an empty line
  assign mark     = (state == FLUSH) && load_ok && !out_done && (cnt == 8'd0);
  assign cnt_pop  = pop ? (cnt - pop_bits) : cnt;
  assign pop_line = (pop_bits == 8'd48) ?
    {sbuf[127:116], 4'h0, sbuf[115:104], 4'h0, sbuf[103:92], 4'h0, sbuf[91:80], 4'h0} :
    {sbuf[127:116], 4'h0, sbuf[115:104], 4'h0, 32'h0};

  always_comb begin
    rdy = 1'b0;
    case (state)
      HDR, TIME, PASS: rdy = load_ok;
      BODY:            rdy = (need == 20'd0) || (cnt_pop <= 8'd64);
      default:         rdy = 1'b0;
    endcase
  end
  assign i_tready = rdy & reset;
  assign acc      = i_tvalid & i_tready;

  // only payload bits are pushed; bits past the announced sample count are dropped
  assign push      = (state == BODY) && acc && (need != 20'd0);
  assign push_bits = (need >= 20'd64) ? 8'd64 : 8'(need);
  assign mask      = ~({128{1'b1}} >> push_bits);
  assign push_v    = ({i_tdata, 64'h0} & mask) >> cnt_pop;
  assign sh        = pop ? (sbuf << pop_bits) : sbuf;

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    hdr_ld   = 1'b0;
    done_nx  = out_done;
    sbuf_nx  = sbuf;
    cnt_nx   = cnt;
    need_nx  = need;
    case (state)
      HDR: if (acc) begin
        if (enable && i_tdata[63:62] == 2'b00) begin
          hdr_ld   = 1'b1;
          state_nx = HDR_OUT;
        end else begin
          ld      = 1'b1;
          ld_data = i_tdata;
          ld_last = i_tlast;
          if (!i_tlast) state_nx = PASS;
        end
      end
      HDR_OUT: if (load_ok) begin
        ld      = 1'b1;
        ld_data = {hdr_hi, olen_q, sid_q};
        ld_last = hdr_last_q || (!hdr_hi[13] && n_q == 15'd0);
        if (hdr_last_q)     state_nx = HDR;
        else if (hdr_hi[13]) state_nx = TIME;
        else begin
          state_nx = BODY;
          done_nx  = (n_q == 15'd0);  // BODY then just drains input
        end
      end
      TIME: if (acc) begin
        ld       = 1'b1;
        ld_data  = i_tdata;
        ld_last  = i_tlast || (n_q == 15'd0);
        done_nx  = (n_q == 15'd0);
        state_nx = i_tlast ? HDR : BODY;
      end
      BODY, FLUSH: begin
        if (pop) begin
          ld      = 1'b1;
          ld_data = pop_line;
          ld_last = pop_last;
          done_nx = out_done | pop_last;
        end else if (mark) begin
          ld      = 1'b1;
          ld_last = 1'b1;
          done_nx = 1'b1;
        end
        sbuf_nx = push ? (sh | push_v) : sh;
        cnt_nx  = cnt_pop + (push ? push_bits : 8'd0);
        if (push) need_nx = need - 20'(push_bits);
        if (state == BODY) begin
          if (acc && i_tlast) begin
            cnt_nx   = floor24(cnt_nx);   // trailing fragment discarded
            need_nx  = '0;
            state_nx = done_nx ? HDR : FLUSH;
          end
        end else if (done_nx) begin
          state_nx = HDR;
        end
      end
      PASS: if (acc) begin
        ld      = 1'b1;
        ld_data = i_tdata;
        ld_last = i_tlast;
        if (i_tlast) state_nx = HDR;
      end
      default: state_nx = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HDR;
      enable     <= 1'b0;
      hdr_hi     <= '0;
      sid_q      <= '0;
      hdr_last_q <= 1'b0;
      n_q        <= '0;
      olen_q     <= '0;
      sbuf       <= '0;
      cnt        <= '0;
      need       <= '0;
      out_done   <= 1'b0;
      o_tvalid   <= 1'b0;
      o_tlast    <= 1'b0;
      o_tdata    <= '0;
    end else begin
      state <= state_nx;
      if (set_stb && set_addr == 8'(BASE)) enable <= set_data[0];
      if (hdr_ld) begin
        hdr_hi     <= i_tdata[63:48];
        sid_q      <= i_tdata[31:0];
        hdr_last_q <= i_tlast;
        n_q        <= n_c;
        olen_q     <= 16'(h_len + {n_c, 2'b00});
        sbuf       <= '0;
        cnt        <= '0;
        need       <= need0;
        out_done   <= 1'b0;
      end else begin
        sbuf     <= sbuf_nx;
        cnt      <= cnt_nx;
        need     <= need_nx;
        out_done <= done_nx;
      end
      if (ld) begin
        o_tvalid <= 1'b1;
        o_tdata  <= ld_data;
        o_tlast  <= ld_last;
      end else if (o_tready) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/chdr_12sc_to_16sc.md
Name: chdr_12sc_to_16sc

Overview:
- Receive-side unpacker for CHDR data packets that carry packed 12-bit complex samples.
- Expands each sample to a 16-bit I / 16-bit Q pair and rewrites the header length field to match.
- Sits directly downstream of the 16sc-to-12sc packer at the far end of a link and feeds radio/DSP consumers that expect sc16.
- Non-data packets, and all traffic while conversion is disabled, pass through unmodified.

Parameters:
- BASE, 0: settings-bus address of the control register.

Ports:
- clk  input  1  clock
- reset  input  1  reset; asynchronous, active-low
- set_stb  input  1  settings write strobe
- set_addr  input  8  settings address
- set_data  input  32  settings data; bit0 = enable conversion
- i_tdata  input  64  CHDR input stream
- i_tlast  input  1  last line of input packet
- i_tvalid  input  1  input valid
- i_tready  output  1  input ready
- o_tdata  output  64  CHDR output stream
- o_tlast  output  1  last line of output packet
- o_tvalid  output  1  output valid
- o_tready  input  1  output ready

Behaviour:
- Reset (reset low, asynchronous) values:
  - o_tvalid=0, o_tlast=0, o_tdata=0.
  - i_tready deasserts; enable=0 (bypass).
  - State HDR; residue buffer cleared.
- Settings register:
  - Write when set_stb && set_addr==BASE; enable<=set_data[0].
  - enable is sampled only at header acceptance; a mid-packet write takes effect on the next packet.
- Header fields:
  - [63:62] type, [61] has_time, [60] eob, [59:48] seqnum, [47:32] length in bytes including header and time, [31:0] SID.
  - H = 16 if has_time, else 8.
- Convert condition: enable==1 and type==2'b00. Otherwise the packet goes to PASS: every line is forwarded verbatim until i_tlast, with i_tready=o_tready.
- Length rewrite:
  - P = length-H.
  - N = floor(P/3), computed as (P*16'hAAAB)>>17; exact for P<65536.
  - out_length = H + 4*N.
  - All other header bits are unchanged.
  - The header spends one register stage in the block, so header latency is 1 cycle after acceptance.
- States:
  - HDR: accept header, latch fields, go to HDR_OUT.
  - HDR_OUT: present the rewritten header. On handshake go to TIME if has_time, else BODY.
  - TIME: timestamp line is forwarded verbatim, then BODY.
  - BODY: unpack.
  - FLUSH: drain the residue after i_tlast.
  - PASS.
  - After a tlast handshake, every state returns to HDR.
- Packing format, input:
  - Sample = 24 bits {I12,Q12}, concatenated MSB-first across lines.
  - Three lines hold 8 samples: line0={s0,s1,s2[23:8]}, line1={s2[7:0],s3,s4,s5[23:16]}, line2={s5[15:0],s6,s7}.
- Packing format, output:
  - Line = {sA_I16,sA_Q16,sB_I16,sB_Q16}, with the earlier sample in the upper 32 bits.
  - I16={I12,4'h0}, Q16={Q12,4'h0} (scale-preserving, no rounding).
- Residue buffer:
  - 128-bit buffer with a valid-bit count.
  - A new input line is accepted only if count+64<=128 after the pending output pop.
  - An output line is available when count>=48.
  - Steady state runs 3 input lines : 4 output lines, so i_tready drops 1 cycle in 4 when o_tready is held high.
- Packet end:
  - On i_tlast the block stops accepting input and goes to FLUSH.
  - Whole samples are emitted; if one sample remains, the last line is {sA,32'h0}.
  - A trailing fragment under 24 bits is discarded.
  - o_tlast is asserted on the final output line.
  - i_tlast governs termination; the header length is not corrected if it disagrees with the actual payload.
  - A packet with N=0 outputs header (plus time) only, with o_tlast on the last of those lines.
- Backpressure:
  - o_tdata, o_tlast and o_tvalid hold stable while o_tvalid && !o_tready.
  - No combinational path from o_tready to o_tvalid.
- Reset mid-packet: the output is dropped immediately, and the next accepted line is treated as a header.

Test Plan:
- Enable=1; header has_time=1, length=40, SID=DEADBEEF; payload 8 samples, s0={I=0x123,Q=0xABC}, s1={0x7FF,0x800} → out header length=48, time line unchanged, body line0=0x1230ABC0_7FF08000, 4 body lines, o_tlast on 4th.
- has_time=0, length=20 (4 samples) → out length=24, 2 body lines, o_tlast on 2nd.
- length=11 (1 sample, has_time=0) → out length=12, single body line {s0,32'h0} with o_tlast.
- Random o_tready (50%) over 16-sample packets → output identical to the o_tready=1 run; no line lost or duplicated; i_tready duty ≤75% when o_tready is held high.
- Enable=0, or type=2'b10 with enable=1 → output bit-identical to input, including length.
- Assert reset mid-body, release, then send a clean 8-sample packet → o_tvalid=0 during reset, and the clean packet converts correctly.
